// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : UART receiver (8 data bits, LSB first, 1 stop bit) feeding a
//                show-ahead receive FIFO, with sticky overrun, framing and
//                parity error flags.
//                Optional feature macro: UART_RX_PARITY_EN adds one
//                even-parity bit between the data bits and the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH_LOG2   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    logic [1:0]           r_sync_fill;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [DEPTH_LOG2:0]  r_wr_ptr;
    logic [DEPTH_LOG2:0]  r_rd_ptr;
    logic [7:0]           r_mem [2**DEPTH_LOG2];
    logic                 r_overrun;
    logic                 r_frame_err;

    logic w_fall;
    logic w_cnt_half;
    logic w_cnt_full;
    logic w_push;
    logic w_frame_evt;
    logic w_empty;
    logic w_full;
    logic w_rd_en;
    logic w_wr_en;
    logic w_ovr_evt;

    // Two-flop synchroniser; r_sync_fill marks when r_rx_sync carries a real
    // line sample so the reset value of the flops can never fake a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_sync_fill <= 2'b00;
            r_rx_prev   <= 1'b0;
        end else begin
            r_rx_meta   <= uart_rx;
            r_rx_sync   <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_rx_prev   <= r_rx_sync & r_sync_fill[1];
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_cnt_half = (r_cnt == c_half_last);
    assign w_cnt_full = (r_cnt == c_bit_last);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_evt;
    logic r_parity_err;
`endif

    // FSM next-state and per-sample event decode
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_evt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_cnt_half) begin
                    w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_full && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_full) begin
                    // Even parity: the received bit must equal the XOR of the data.
                    w_par_evt   = (r_rx_sync != (^r_shift));
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_full) begin
                    if (r_rx_sync) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_evt = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_sync) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample counter: restarts on every state change, wraps once per bit time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_BREAK)) begin
            r_cnt <= '0;
        end else if (w_cnt_full) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Data shift register and bit counter, LSB arrives first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else if ((r_state == S_DATA) && w_cnt_full) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
        end else if (r_state != S_DATA) begin
            r_bit_cnt <= 3'd0;
        end
    end

    // FIFO status; a pop on a full FIFO frees the slot for a same-cycle push
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_rd_en   = rd & ~w_empty;
    assign w_wr_en   = w_push & (~w_full | w_rd_en);
    assign w_ovr_evt = w_push & w_full & ~w_rd_en;

    // FIFO pointers with one extra wrap bit for full/empty distinction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observable through non-empty slots
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= r_shift;
        end
    end

    // Sticky error flags; a same-cycle error event takes priority over clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, same priority rule as the other flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (w_par_evt) begin
            r_parity_err <= 1'b1;
        end else if (clr_err) begin
            r_parity_err <= 1'b0;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data_valid = ~w_empty;
    assign data_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo: directed vector table,
//                hand-written corner sequences and a randomized frame stream
//                compared against a queue-based frame-level model.
//                Honours UART_RX_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLKS_PER_BIT = 16;
    localparam int DEPTH_LOG2   = 2;
    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam time BIT_T       = 160;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_ferr;
    logic       m_perr;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DEPTH_LOG2   (DEPTH_LOG2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rd         (rd),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Serial frame: start, 8 data bits LSB first, optional parity, stop, one idle bit
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
        uart_rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            #(BIT_T);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = par_ok ? (^d) : ~(^d);
        #(BIT_T);
`else
        if (par_ok) uart_rx = 1'b1;
`endif
        uart_rx = stop_b;
        #(BIT_T);
        uart_rx = 1'b1;
        #(BIT_T);
    endtask

    task automatic pulse_rd();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"}, data_valid, (m_q.size() != 0));
        if (m_q.size() != 0) chk({tag, " data"}, data_out, m_q[0]);
        chk({tag, " overrun"}, overrun, m_ovr);
        chk({tag, " frame_err"}, frame_err, m_ferr);
        chk({tag, " parity_err"}, parity_err, m_perr);
    endtask

    initial begin
        vec_t       tbl[5];
        logic [7:0] d;
        logic       stop_ok;
        logic       par_ok;
        int         nrd;

        tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b0};

        n_tests = 0;
        n_fail  = 0;
        rd      = 1'b0;
        clr_err = 1'b0;
        uart_rx = 1'b0;
        reset   = 1'b1;

        // Reset state must appear before any clock edge
        #3;
        chk("reset valid", data_valid, 1'b0);
        chk("reset data", data_out, 8'h00);
        chk("reset overrun", overrun, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset parity_err", parity_err, 1'b0);

        // Line held low across reset release: no frame may be accepted
        #47;
        reset = 1'b0;
        #(2 * BIT_T);
        uart_rx = 1'b1;
        #(12 * BIT_T);
        chk("low-at-release valid", data_valid, 1'b0);
        chk("low-at-release frame_err", frame_err, 1'b0);

        // Directed single-frame vectors
        for (int v = 0; v < 5; v++) begin
            send_frame(tbl[v].data, tbl[v].stop, 1'b1);
            chk($sformatf("vec%0d valid", v), data_valid, tbl[v].exp_valid);
            if (tbl[v].exp_valid) chk($sformatf("vec%0d data", v), data_out, tbl[v].data);
            chk($sformatf("vec%0d frame_err", v), frame_err, tbl[v].exp_ferr);
            chk($sformatf("vec%0d parity_err", v), parity_err, 1'b0);
            if (tbl[v].exp_valid) begin
                pulse_rd();
                chk($sformatf("vec%0d valid after rd", v), data_valid, 1'b0);
            end
            if (tbl[v].exp_ferr) begin
                pulse_clr();
                chk($sformatf("vec%0d frame_err after clr", v), frame_err, 1'b0);
            end
        end

        // Short glitch must be rejected
        uart_rx = 1'b0;
        #30;
        uart_rx = 1'b1;
        #(3 * BIT_T);
        chk("glitch valid", data_valid, 1'b0);
        chk("glitch frame_err", frame_err, 1'b0);
        chk("glitch overrun", overrun, 1'b0);

        // ReaD on empty FIFO has no effect
        pulse_rd();
        chk("rd empty valid", data_valid, 1'b0);

        // Overrun: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        chk("ovr flag", overrun, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("ovr valid %0d", i), data_valid, 1'b1);
            chk($sformatf("ovr data %0d", i), data_out, 8'(i));
            pulse_rd();
        end
        chk("ovr drained valid", data_valid, 1'b0);
        pulse_clr();
        chk("ovr cleared", overrun, 1'b0);

        // Reset in the middle of bit 4 of frame 0xFF
        uart_rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            uart_rx = 1'b1;
            if (i == 4) begin
                #(BIT_T / 2);
                reset = 1'b1;
                #20;
                reset = 1'b0;
                #(BIT_T / 2 - 20);
            end else begin
                #(BIT_T);
            end
        end
        uart_rx = 1'b1;
        #(3 * BIT_T);
        chk("midreset valid", data_valid, 1'b0);
        chk("midreset frame_err", frame_err, 1'b0);
        send_frame(8'h12, 1'b1, 1'b1);
        chk("post-reset valid", data_valid, 1'b1);
        chk("post-reset data", data_out, 8'h12);
        pulse_rd();

`ifdef UART_RX_PARITY_EN
        // Wrong parity: flag set, byte still stored
        send_frame(8'h07, 1'b1, 1'b0);
        chk("parity flag", parity_err, 1'b1);
        chk("parity valid", data_valid, 1'b1);
        chk("parity data", data_out, 8'h07);
        pulse_rd();
        pulse_clr();
        chk("parity cleared", parity_err, 1'b0);
`endif

        // Randomized frame stream against the queue model
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 5) != 0);
            send_frame(d, stop_ok, par_ok);
`ifdef UART_RX_PARITY_EN
            if (!par_ok) m_perr = 1'b1;
`endif
            if (stop_ok) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovr = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
            check_model($sformatf("rnd%0d rx", n));
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) begin
                pulse_rd();
                if (m_q.size() != 0) void'(m_q.pop_front());
            end
            if (nrd != 0) check_model($sformatf("rnd%0d rd", n));
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
                m_perr = 1'b0;
                check_model($sformatf("rnd%0d clr", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
